// File: rtl/qpu_exu_alu_rslt_buf.sv
// ALU result FIFO feeding one commit and NWB write-back channels from its head; an entry is on the head outputs one cycle after push.
// i_ready = count < DEPTH; each channel handshakes alone, so a stalled channel holds only the head entry.
module qpu_exu_alu_rslt_buf #(
    parameter int NWB          = 4,
    parameter int DATA_W       = 32,
    parameter int PC_W         = 32,
    parameter int RFIDX_W      = 6,
    parameter int DEPTH        = 2,
    parameter int CMT_AFTER_WB = 0,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [PC_W-1:0]       i_pc,
    input  logic [DATA_W-1:0]     i_imm,
    input  logic                  i_bjp,
    input  logic                  i_bjp_prdt,
    input  logic                  i_bjp_rslv,
    input  logic [NWB-1:0]        i_wb_need,
    input  logic [NWB*DATA_W-1:0] i_wb_data,
    input  logic [RFIDX_W-1:0]    i_rdidx,
    output logic                  cmt_o_valid,
    input  logic                  cmt_o_ready,
    output logic [PC_W-1:0]       cmt_o_pc,
    output logic [DATA_W-1:0]     cmt_o_imm,
    output logic                  cmt_o_bjp,
    output logic                  cmt_o_bjp_prdt,
    output logic                  cmt_o_bjp_rslv,
    output logic [NWB-1:0]        wbck_o_valid,
    input  logic [NWB-1:0]        wbck_o_ready,
    output logic [NWB*DATA_W-1:0] wbck_o_data,
    output logic [RFIDX_W-1:0]    wbck_o_rdidx,
    output logic [CW-1:0]         o_count,
    output logic                  o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [DATA_W-1:0]     imm;
        logic                  bjp;
        logic                  bjp_prdt;
        logic                  bjp_rslv;
        logic [NWB-1:0]        wb_need;
        logic [NWB*DATA_W-1:0] wb_data;
        logic [RFIDX_W-1:0]    rdidx;
    } ent_t;

    ent_t           ent_q [DEPTH];
    ent_t           ent_in;
    ent_t           head;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           cmt_done;
    logic [NWB-1:0] wb_done;
    logic           empty;
    logic           push;
    logic           pop;
    logic           cmt_fire;
    logic [NWB-1:0] wb_fire;
    logic [NWB-1:0] wb_pend;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Unneeded data slices are zeroed on the way in, so the head needs no output masking per channel.
    always_comb begin
        ent_in          = '0;
        ent_in.pc       = i_pc;
        ent_in.imm      = i_imm;
        ent_in.bjp      = i_bjp;
        ent_in.bjp_prdt = i_bjp_prdt;
        ent_in.bjp_rslv = i_bjp_rslv;
        ent_in.wb_need  = i_wb_need;
        ent_in.rdidx    = i_rdidx;
        for (int k = 0; k < NWB; k++) begin
            ent_in.wb_data[k*DATA_W +: DATA_W] = i_wb_need[k] ? i_wb_data[k*DATA_W +: DATA_W] : '0;
        end
    end

    assign empty   = (count == '0);
    assign i_ready = (count < CW'(DEPTH));
    assign push    = i_valid & i_ready;
    assign head    = empty ? '0 : ent_q[rd_ptr];

    assign wb_pend      = head.wb_need & ~wb_done;
    assign wbck_o_valid = wb_pend;
    assign cmt_o_valid  = ~empty & ~cmt_done & ((CMT_AFTER_WB == 0) || (wb_pend == '0));
    assign wb_fire      = wbck_o_valid & wbck_o_ready;
    assign cmt_fire     = cmt_o_valid & cmt_o_ready;
    assign pop          = ~empty & (cmt_fire | cmt_done) & ((head.wb_need & ~(wb_fire | wb_done)) == '0);

    assign cmt_o_pc       = head.pc;
    assign cmt_o_imm      = head.imm;
    assign cmt_o_bjp      = head.bjp;
    assign cmt_o_bjp_prdt = head.bjp_prdt;
    assign cmt_o_bjp_rslv = head.bjp_rslv;
    assign wbck_o_data    = head.wb_data;
    assign wbck_o_rdidx   = head.rdidx;
    assign o_count        = count;
    assign o_empty        = empty;

    always_ff @(posedge clk) begin
        if (push) begin
            ent_q[wr_ptr] <= ent_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cmt_done <= 1'b0;
            wb_done  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            // Done bits track only the head, so they clear whenever it retires.
            if (pop) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                cmt_done <= 1'b0;
                wb_done  <= '0;
            end else begin
                cmt_done <= cmt_done | cmt_fire;
                wb_done  <= wb_done | wb_fire;
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_qpu_exu_alu_rslt_buf.sv
// Drives three buffer instances (DEPTH 2 / ordered DEPTH 2 / DEPTH 3) with directed vectors;
// a negedge monitor pops expected payloads from a scoreboard on every channel fire.
module tb_qpu_exu_alu_rslt_buf;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]        rst, i_valid, i_bjp, i_bjp_prdt, i_bjp_rslv, cmt_o_ready;
    logic [N-1:0]        i_ready, cmt_o_valid, cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_bjp_rslv, o_empty;
    logic [N-1:0][31:0]  i_pc, i_imm, cmt_o_pc, cmt_o_imm;
    logic [N-1:0][3:0]   i_wb_need, wbck_o_ready, wbck_o_valid;
    logic [N-1:0][127:0] i_wb_data, wbck_o_data;
    logic [N-1:0][5:0]   i_rdidx, wbck_o_rdidx;
    logic [N-1:0][1:0]   o_count;

    for (genvar g = 0; g < N; g++) begin : g_dut
        qpu_exu_alu_rslt_buf #(
            .NWB(4), .DATA_W(32), .PC_W(32), .RFIDX_W(6),
            .DEPTH(g == 2 ? 3 : 2), .CMT_AFTER_WB(g == 1 ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst[g]),
            .i_valid(i_valid[g]), .i_ready(i_ready[g]),
            .i_pc(i_pc[g]), .i_imm(i_imm[g]),
            .i_bjp(i_bjp[g]), .i_bjp_prdt(i_bjp_prdt[g]), .i_bjp_rslv(i_bjp_rslv[g]),
            .i_wb_need(i_wb_need[g]), .i_wb_data(i_wb_data[g]), .i_rdidx(i_rdidx[g]),
            .cmt_o_valid(cmt_o_valid[g]), .cmt_o_ready(cmt_o_ready[g]),
            .cmt_o_pc(cmt_o_pc[g]), .cmt_o_imm(cmt_o_imm[g]),
            .cmt_o_bjp(cmt_o_bjp[g]), .cmt_o_bjp_prdt(cmt_o_bjp_prdt[g]), .cmt_o_bjp_rslv(cmt_o_bjp_rslv[g]),
            .wbck_o_valid(wbck_o_valid[g]), .wbck_o_ready(wbck_o_ready[g]),
            .wbck_o_data(wbck_o_data[g]), .wbck_o_rdidx(wbck_o_rdidx[g]),
            .o_count(o_count[g]), .o_empty(o_empty[g])
        );
    end

    typedef struct packed {
        logic [1:0]  d;
        logic [2:0]  ch;   // 0..3 write-back channel, 4 commit
        logic [31:0] v0;
        logic [31:0] v1;
        logic [2:0]  f;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_match(input logic [1:0] d, input logic [2:0] ch, input logic [31:0] v0,
                            input logic [31:0] v1, input logic [2:0] f);
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].d == d && exp_q[i].ch == ch) begin
                idx = i;
                break;
            end
        end
        if (idx < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected dut%0d ch%0d: fire with v0=%0h, no entry expected", d, ch, v0);
        end else begin
            chk($sformatf("sb_v0 dut%0d ch%0d", d, ch), 128'(v0), 128'(exp_q[idx].v0));
            chk($sformatf("sb_v1 dut%0d ch%0d", d, ch), 128'(v1), 128'(exp_q[idx].v1));
            chk($sformatf("sb_flags dut%0d ch%0d", d, ch), 128'(f), 128'(exp_q[idx].f));
            exp_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            if (cmt_o_valid[d] && cmt_o_ready[d])
                sb_match(2'(d), 3'd4, cmt_o_pc[d], cmt_o_imm[d],
                         {cmt_o_bjp[d], cmt_o_bjp_prdt[d], cmt_o_bjp_rslv[d]});
            for (int k = 0; k < 4; k++) begin
                if (wbck_o_valid[d][k] && wbck_o_ready[d][k])
                    sb_match(2'(d), 3'(k), wbck_o_data[d][k*32 +: 32], {26'd0, wbck_o_rdidx[d]}, 3'd0);
            end
            if (!rst[d])
                chk($sformatf("occupancy_bound dut%0d", d), 128'(o_count[d] <= 2'(d == 2 ? 3 : 2)), 128'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Must be entered just after a rising edge; returns just after the accepting edge.
    task automatic send(input int d, input logic [31:0] pc, input logic [3:0] need, input logic [31:0] dat);
        int w = 0;
        i_valid[d]   = 1'b1;
        i_pc[d]      = pc;
        i_imm[d]     = pc + 32'd100;
        {i_bjp[d], i_bjp_prdt[d], i_bjp_rslv[d]} = pc[2:0];
        i_wb_need[d] = need;
        i_rdidx[d]   = pc[5:0];
        for (int k = 0; k < 4; k++) i_wb_data[d][k*32 +: 32] = dat | (32'(k) << 24);
        forever begin
            @(negedge clk);
            if (i_ready[d]) break;
            w++;
            if (w > 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout dut%0d pc %0h: i_ready stayed 0, required 1", d, pc);
                i_valid[d] = 1'b0;
                return;
            end
            tick();
        end
        exp_q.push_back('{2'(d), 3'd4, pc, pc + 32'd100, pc[2:0]});
        for (int k = 0; k < 4; k++)
            if (need[k]) exp_q.push_back('{2'(d), 3'(k), dat | (32'(k) << 24), {26'd0, pc[5:0]}, 3'd0});
        tick();
        i_valid[d] = 1'b0;
    endtask

    task automatic wait_empty(input int d, input int bound);
        int w = 0;
        while (!o_empty[d]) begin
            w++;
            if (w > bound) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain_timeout dut%0d: o_empty=0 count=%0d, required 1", d, o_count[d]);
                return;
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = '1; i_valid = '0; i_pc = '0; i_imm = '0; i_bjp = '0; i_bjp_prdt = '0; i_bjp_rslv = '0;
        i_wb_need = '0; i_wb_data = '0; i_rdidx = '0; cmt_o_ready = '1; wbck_o_ready = '1;
        repeat (2) tick();
        rst = '0;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            chk($sformatf("rst_i_ready dut%0d", d), 128'(i_ready[d]), 128'd1);
            chk($sformatf("rst_empty dut%0d", d), 128'(o_empty[d]), 128'd1);
            chk($sformatf("rst_count dut%0d", d), 128'(o_count[d]), 128'd0);
            chk($sformatf("rst_cmt_valid dut%0d", d), 128'(cmt_o_valid[d]), 128'd0);
            chk($sformatf("rst_wb_valid dut%0d", d), 128'(wbck_o_valid[d]), 128'd0);
            chk($sformatf("rst_payload dut%0d", d), {cmt_o_pc[d], cmt_o_imm[d], 26'd0, wbck_o_rdidx[d], 32'd0}, 128'd0);
            chk($sformatf("rst_wb_data dut%0d", d), wbck_o_data[d], 128'd0);
        end

        // Single entry, commit plus wb0.
        tick();
        send(0, 32'h100, 4'b0001, 32'h11);
        @(negedge clk);
        chk("single_cmt_valid", 128'(cmt_o_valid[0]), 128'd1);
        chk("single_wb_valid", 128'(wbck_o_valid[0]), 128'b0001);
        chk("single_count", 128'(o_count[0]), 128'd1);
        tick();
        @(negedge clk);
        chk("single_count_after", 128'(o_count[0]), 128'd0);
        chk("single_empty_after", 128'(o_empty[0]), 128'd1);

        // Split completion, channel 2 stalled for three cycles.
        tick();
        wbck_o_ready[0] = 4'b1011;
        send(0, 32'h204, 4'b0101, 32'h22);
        @(negedge clk);
        chk("split_c1_cmt_valid", 128'(cmt_o_valid[0]), 128'd1);
        chk("split_c1_wb_valid", 128'(wbck_o_valid[0]), 128'b0101);
        chk("split_mask_slice1", 128'(wbck_o_data[0][63:32]), 128'd0);
        chk("split_mask_slice3", 128'(wbck_o_data[0][127:96]), 128'd0);
        for (int c = 2; c <= 3; c++) begin
            tick();
            @(negedge clk);
            chk($sformatf("split_c%0d_cmt_valid", c), 128'(cmt_o_valid[0]), 128'd0);
            chk($sformatf("split_c%0d_wb_valid", c), 128'(wbck_o_valid[0]), 128'b0100);
            chk($sformatf("split_c%0d_count", c), 128'(o_count[0]), 128'd1);
        end
        tick();
        wbck_o_ready[0] = 4'hF;
        @(negedge clk);
        chk("split_c4_wb_valid", 128'(wbck_o_valid[0]), 128'b0100);
        tick();
        @(negedge clk);
        chk("split_empty_after", 128'(o_empty[0]), 128'd1);

        // Full: two entries fill DEPTH=2, third waits until the head drains.
        tick();
        cmt_o_ready[0] = 1'b0;
        wbck_o_ready[0] = 4'h0;
        send(0, 32'h301, 4'b0011, 32'h31);
        send(0, 32'h302, 4'b0011, 32'h32);
        @(negedge clk);
        chk("full_count", 128'(o_count[0]), 128'd2);
        chk("full_i_ready", 128'(i_ready[0]), 128'd0);
        tick();
        fork
            send(0, 32'h303, 4'b0011, 32'h33);
            begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    chk("full_hold_i_ready", 128'(i_ready[0]), 128'd0);
                    chk("full_hold_count", 128'(o_count[0]), 128'd2);
                    tick();
                end
                cmt_o_ready[0] = 1'b1;
                wbck_o_ready[0] = 4'hF;
            end
        join
        wait_empty(0, 20);

        // Ordered commit: wb0/wb1 first, commit one cycle later.
        tick();
        send(1, 32'h401, 4'b0011, 32'h41);
        @(negedge clk);
        chk("ordered_c1_wb_valid", 128'(wbck_o_valid[1]), 128'b0011);
        chk("ordered_c1_cmt_valid", 128'(cmt_o_valid[1]), 128'd0);
        tick();
        @(negedge clk);
        chk("ordered_c2_cmt_valid", 128'(cmt_o_valid[1]), 128'd1);
        chk("ordered_c2_wb_valid", 128'(wbck_o_valid[1]), 128'b0000);
        tick();
        @(negedge clk);
        chk("ordered_empty_after", 128'(o_empty[1]), 128'd1);

        // Reset with two entries queued and wb0 of the head already done.
        tick();
        cmt_o_ready[0] = 1'b0;
        wbck_o_ready[0] = 4'b0001;
        send(0, 32'h501, 4'b0011, 32'h51);
        send(0, 32'h502, 4'b0011, 32'h52);
        @(negedge clk);
        chk("rstmid_count_before", 128'(o_count[0]), 128'd2);
        chk("rstmid_wb_valid_before", 128'(wbck_o_valid[0]), 128'b0010);
        tick();
        rst[0] = 1'b1;
        wbck_o_ready[0] = 4'h0;
        tick();
        rst[0] = 1'b0;
        @(negedge clk);
        chk("rstmid_count", 128'(o_count[0]), 128'd0);
        chk("rstmid_cmt_valid", 128'(cmt_o_valid[0]), 128'd0);
        chk("rstmid_wb_valid", 128'(wbck_o_valid[0]), 128'd0);
        chk("rstmid_i_ready", 128'(i_ready[0]), 128'd1);
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].d == 2'd0) exp_q.delete(i);
        cmt_o_ready[0] = 1'b1;
        wbck_o_ready[0] = 4'hF;

        // Wrap-around on DEPTH=3: seven back-to-back entries, one per cycle.
        tick();
        c0 = cyc;
        fork
            for (int k = 1; k <= 7; k++) send(2, 32'h600 + 32'(k), 4'b0001, 32'(k));
            for (int k = 1; k <= 7; k++) begin
                @(posedge clk);
                @(negedge clk);
                chk($sformatf("wrap_count_%0d", k), 128'(o_count[2]), 128'd1);
                chk($sformatf("wrap_data_%0d", k), 128'(wbck_o_data[2][31:0]), 128'(k));
            end
        join
        chk("wrap_cycles", 128'(cyc - c0), 128'd7);
        tick();
        wait_empty(2, 10);

        repeat (3) tick();
        chk("sb_leftover", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/qpu_exu_alu_rslt_buf.md
# qpu_exu_alu_rslt_buf

Parametrised result buffer between the QPU ALU execution block and the commit/write-back stages. It accepts one fully resolved instruction result per cycle and queues it in a DEPTH-entry FIFO. The head entry drives one commit channel and NWB independent write-back channels (classical, quantum-classical, time, event, …). Each channel handshakes on its own, so a stalled write-back port no longer blocks commit or the other ports, and the entry retires once every required channel has fired.

## Interface
Parameters:
- NWB, 4: number of write-back channels.
- DATA_W, 32: write-back data and imm width.
- PC_W, 32: PC width.
- RFIDX_W, 6: destination register index width.
- DEPTH, 2: FIFO entries, at least 1.
- CMT_AFTER_WB, 0: when 1, commit is held until all required write-backs of the entry are done.

Ports (CW = $clog2(DEPTH+1)):
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous reset, active-high.
- i_valid  in  1  result valid.
- i_ready  out  1  buffer can accept; equals count < DEPTH.
- i_pc  in  PC_W  instruction PC.
- i_imm  in  DATA_W  immediate passed to commit.
- i_bjp, i_bjp_prdt, i_bjp_rslv  in  1 each  branch flags.
- i_wb_need  in  NWB  required write-back channels.
- i_wb_data  in  NWB*DATA_W  per-channel data; slice k is [k*DATA_W +: DATA_W].
- i_rdidx  in  RFIDX_W  destination index.
- cmt_o_valid  out  1  commit valid.
- cmt_o_ready  in  1  commit ready.
- cmt_o_pc, cmt_o_imm, cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_bjp_rslv  out  commit payload.
- wbck_o_valid  out  NWB  per-channel write-back valid.
- wbck_o_ready  in  NWB  per-channel write-back ready.
- wbck_o_data  out  NWB*DATA_W  per-channel write-back data.
- wbck_o_rdidx  out  RFIDX_W  shared destination index.
- o_count  out  CW  occupancy.
- o_empty  out  1  high when count == 0.

## Operation
- Storage:
  - DEPTH entries holding {pc, imm, bjp flags, wb_need, wb_data, rdidx}.
  - Write pointer, read pointer and a count register.
  - Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of 2.
- Push happens when i_valid & i_ready. The entry is written at the write pointer and the write pointer advances.
- Head state consists of the registers cmt_done and wb_done[NWB]. Both apply only to the entry at the read pointer.
- Head outputs:
  - wbck_o_valid[k] = ~empty & head.wb_need[k] & ~wb_done[k].
  - cmt_o_valid = ~empty & ~cmt_done & (CMT_AFTER_WB==0 | (head.wb_need & ~wb_done) == 0).
- Fire events:
  - A channel fires on valid & ready. The corresponding done bit is set at the next edge unless the entry pops that cycle.
  - Each channel fires at most once per entry.
- Pop:
  - Condition: ~empty, cmt fired or cmt_done, and for every k with wb_need[k] set, wbck fired or wb_done[k].
  - On pop the read pointer advances and all done bits clear.
- Count:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged.
- Write-back mask of all zeros: the entry needs only commit and pops on the commit fire.
- Payload masking: every head payload output is 0 while empty, and wbck_o_data slice k is 0 unless wb_need[k] is set.
- Unused input slices, where wb_need[k] is 0, are not stored or are stored as zero.
- Assertions for the bench:
  - Never push when count == DEPTH.
  - Never pop when empty.

## Timing
- Reset, synchronous: pointers, count and done bits go to 0 and stored entries are discarded. After the reset edge every output is 0 except i_ready = 1 and o_empty = 1.
- Reset asserted mid-operation drops all pending entries with no partial handshakes. Valids are 0 in the cycle after the edge.
- Latency:
  - An entry pushed at edge N is visible on the head outputs in cycle N+1, provided it is the head.
  - There is no combinational path from input to output.
- Throughput: one entry per cycle when all required readies are high. Pushes are accepted while count < DEPTH; i_ready does not depend on pop in the same cycle.
- Valid never depends combinationally on any ready of the same channel.
- With CMT_AFTER_WB=1, commit asserts at the earliest one cycle after the last required write-back fire.
- Payload of an asserted valid stays stable until that channel fires.

## Test plan
- Single entry, need=4'b0001, all readies high: push at edge 0. In cycle 1 cmt_o_valid=1 and wbck_o_valid=4'b0001, and both fire. After edge 2, count=0 and o_empty=1.
- Split completion, need=4'b0101, wbck_o_ready[2]=0 for cycles 1-3:
  - Cycle 1: cmt and wb0 fire.
  - Cycles 2-3: their valids are 0 and wbck_o_valid=4'b0100.
  - Cycle 4: ready[2]=1, wb2 fires, pop follows.
- Full (DEPTH=2), all readies low, i_valid held high with 3 entries: i_ready drops after 2 pushes and count=2. Release all readies: entries drain in order and the third entry is accepted.
- Ordered mode, CMT_AFTER_WB=1, need=4'b0011, readies high: wb0 and wb1 fire in cycle 1 with cmt_o_valid=0. cmt_o_valid=1 in cycle 2, then pop.
- Reset with 2 entries queued and wb_done partially set: one cycle later count=0, all valids are 0, and i_ready=1.
- Wrap-around (DEPTH=3), 7 back-to-back pushes with data 1..7 and readies high: outputs show 1..7 in order at one per cycle, and the pointers wrap twice without loss.
